qspi_arb: RTL and testbench
===========================

Name: qspi_arb

Overview:
- Arbitrates the single QSPI line-transfer engine between icache fills and dcache write-backs/fills.
- Replaces the combinational request/i_d/write/paddr muxing at the qspi port with a registered grant state machine.
- Each transfer is locked to one requester until the engine signals completion.
- Sits between icache/dcache (pull/push/tag) and qspi (req/i_d/write/mem/paddr).

Parameters:
- PA, 22, physical address width.
- LINE_LENGTH, 4, cache line length in bytes. Tag width TW = PA-$clog2(LINE_LENGTH).
- STARVE, 4, maximum consecutive dcache grants while i_req waits. Range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  icache miss needing a line pull (ifetch&i_pull)
- i_tag  in  TW  icache line tag
- i_rom  in  1  icache access targets ROM/flash region
- d_push_req  in  1  dcache dirty line must be written back
- d_pull_req  in  1  dcache miss needing a line pull
- d_tag  in  TW  dcache line tag (victim tag while pushing, miss tag while pulling)
- d_rom  in  1  dcache access targets ROM region (forced 0 for pushes)
- q_req  out  1  transfer request to qspi
- q_i_d  out  1  1 = transfer belongs to icache
- q_write  out  1  1 = line write (push)
- q_mem  out  1  ROM select for the transfer
- q_paddr  out  TW  line tag of the transfer
- q_done  in  1  one-cycle pulse from qspi: last nibble of the current transfer moved
- i_grant  out  1  icache owns the engine (steers wstrobe_i)
- d_grant  out  1  dcache owns the engine (steers wstrobe_d/rstrobe_d/dwrite)
- i_done  out  1  one-cycle pulse: icache fill finished
- d_done  out  1  one-cycle pulse: dcache push or pull finished
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, I_FILL, D_PUSH, D_PULL. Encoding is free.
- Reset (synchronous, at the clock edge):
  - state = IDLE, starvation counter = 0.
  - Outputs: q_req, q_i_d, q_write, q_mem, i_grant, d_grant, i_done, d_done, busy all 0; q_paddr = 0.
  - Reset during a transfer abandons it. q_req is 0 in the cycle after the reset edge.
- IDLE: requests are sampled each cycle. The winner is registered, and the grant, q_req and q_* outputs assert the next cycle. Grant latency is 1 cycle.
- Priority, evaluated in IDLE:
  1. i_req && cnt==STARVE wins, and the icache is served.
  2. Otherwise d_push_req wins.
  3. Otherwise d_pull_req wins.
  4. Otherwise i_req wins.
- On entering a state, latch the transfer attributes:
  - q_paddr = tag of the winner.
  - q_i_d = 1 for I_FILL only.
  - q_write = 1 for D_PUSH only.
  - q_mem = i_rom for I_FILL, d_rom for D_PULL, 0 for D_PUSH.
  - These outputs are held constant until q_done, even if the inputs change.
- Any active state: q_req = 1 and the matching grant = 1 from the entry cycle through the q_done cycle inclusive.
  - Requester deassertion mid-transfer is ignored; qspi cannot abort.
- On q_done:
  - Pulse i_done or d_done in the same cycle, combinationally from q_done & state.
  - D_PUSH with d_pull_req high: go directly to D_PULL next cycle with a fresh latch of d_tag/d_rom. No IDLE bubble. The push and pull count as one dcache grant.
  - Otherwise: go to IDLE. q_req is 0 for at least one cycle, because qspi needs CS high between transfers.
- Starvation counter (4 bits, saturating at STARVE):
  - Increments on each IDLE->D_PUSH or IDLE->D_PULL transition while i_req = 1.
  - Clears on entry to I_FILL.
  - Clears when i_req = 0 in IDLE.
- q_done while in IDLE: ignored, no done pulse, no state change.
- Simultaneous arrival of i_req and a d request: the d request wins unless the counter is saturated.
- q_done in the entry cycle is legal: the transfer completes that cycle, giving a 1-cycle transfer.

Test Plan:
1. Reset, then i_req=1, i_tag=0x12345, i_rom=1. Expect:
   - Next cycle: q_req=1, q_i_d=1, q_write=0, q_mem=1, q_paddr=0x12345, i_grant=1.
   - Pulse q_done 20 cycles later: i_done=1 for one cycle, then q_req=0 and busy=0.
2. d_push_req=1 and d_pull_req=1 with d_tag=0x00A0. Expect:
   - D_PUSH: q_write=1, q_mem=0.
   - On q_done: d_done pulse, then next cycle D_PULL with q_write=0 and q_paddr equal to the new d_tag 0x00B0. q_req never drops between the two transfers.
3. i_req and d_pull_req rise in the same cycle. Expect d_grant first; after q_done, one IDLE cycle, then i_grant.
4. Starvation with STARVE=4: hold i_req=1 and re-assert d_pull_req after every d_done. Expect:
   - The first 4 grants go to the dcache; the 5th goes to the icache even though d_pull_req=1.
   - The counter reads 0 after I_FILL entry.
5. Mid-transfer: change i_tag from 0x11111 to 0x22222 and drop i_req during I_FILL. Expect q_paddr to stay 0x11111 and q_req to stay 1 until q_done. Then assert reset mid D_PULL: next cycle all outputs 0 and state IDLE.
6. Stray q_done pulse in IDLE with no requests. Expect no i_done/d_done pulse, busy=0, q_req=0.

Source files
------------

// File: rtl/qspi_arb.sv
// qspi_arb: registered arbiter for the single QSPI line-transfer engine.
// Grants the engine to icache fills or dcache pushes/pulls; each transfer
// stays locked to its owner until qspi pulses q_done.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   i_req/i_tag/i_rom        icache line-pull request, tag, ROM select
//   d_push_req/d_pull_req    dcache write-back / line-pull requests
//   d_tag/d_rom              dcache tag (victim or miss), ROM select
//   q_req/q_i_d/q_write      request, owner, direction toward qspi
//   q_mem/q_paddr            ROM select and line tag of the transfer
//   q_done                   qspi: last nibble of current transfer moved
//   i_grant/d_grant          current engine owner (strobe steering)
//   i_done/d_done            one-cycle completion pulses
//   busy                     a transfer is in progress
module qspi_arb #(
    parameter int PA          = 22,
    parameter int LINE_LENGTH = 4,
    parameter int STARVE      = 4,
    localparam int TW         = PA - $clog2(LINE_LENGTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [TW-1:0] i_tag,
    input  logic          i_rom,
    input  logic          d_push_req,
    input  logic          d_pull_req,
    input  logic [TW-1:0] d_tag,
    input  logic          d_rom,
    output logic          q_req,
    output logic          q_i_d,
    output logic          q_write,
    output logic          q_mem,
    output logic [TW-1:0] q_paddr,
    input  logic          q_done,
    output logic          i_grant,
    output logic          d_grant,
    output logic          i_done,
    output logic          d_done,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, I_FILL, D_PUSH, D_PULL} state_t;

    localparam logic [3:0] STARVE_C = 4'(STARVE);

    state_t     state, state_nxt;
    logic       load;   // latch transfer attributes for the state being entered
    logic [3:0] cnt;    // consecutive dcache grants while i_req waits

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && cnt == STARVE_C) state_nxt = I_FILL;
                else if (d_push_req)          state_nxt = D_PUSH;
                else if (d_pull_req)          state_nxt = D_PULL;
                else if (i_req)               state_nxt = I_FILL;
                load = (state_nxt != IDLE);
            end
            I_FILL: if (q_done) state_nxt = IDLE;
            D_PUSH: begin
                // Write-back followed by the miss fill chains without an IDLE
                // bubble; both halves count as a single dcache grant.
                if (q_done) begin
                    if (d_pull_req) begin
                        state_nxt = D_PULL;
                        load      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            D_PULL: if (q_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign q_req   = busy;
    assign i_grant = (state == I_FILL);
    assign d_grant = (state == D_PUSH) || (state == D_PULL);
    assign i_done  = q_done && i_grant;
    assign d_done  = q_done && d_grant;

    // Attributes are frozen for the whole transfer; requester inputs may move.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_paddr <= '0;
            q_i_d   <= 1'b0;
            q_write <= 1'b0;
            q_mem   <= 1'b0;
        end else if (load) begin
            q_paddr <= (state_nxt == I_FILL) ? i_tag : d_tag;
            q_i_d   <= (state_nxt == I_FILL);
            q_write <= (state_nxt == D_PUSH);
            q_mem   <= (state_nxt == I_FILL) ? i_rom :
                       (state_nxt == D_PULL) ? d_rom : 1'b0;
        end else if (state_nxt == IDLE) begin
            q_paddr <= '0;
            q_i_d   <= 1'b0;
            q_write <= 1'b0;
            q_mem   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            if (!i_req || state_nxt == I_FILL)
                cnt <= '0;
            else if (state_nxt != IDLE && cnt != STARVE_C)
                cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_qspi_arb.sv
module tb_qspi_arb;

    localparam int TW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, i_rom, d_push_req, d_pull_req, d_rom, q_done;
    logic [TW-1:0] i_tag, d_tag;
    logic          q_req, q_i_d, q_write, q_mem, i_grant, d_grant, i_done, d_done, busy;
    logic [TW-1:0] q_paddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qspi_arb #(.PA(22), .LINE_LENGTH(4), .STARVE(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_tag(i_tag), .i_rom(i_rom),
        .d_push_req(d_push_req), .d_pull_req(d_pull_req), .d_tag(d_tag), .d_rom(d_rom),
        .q_req(q_req), .q_i_d(q_i_d), .q_write(q_write), .q_mem(q_mem), .q_paddr(q_paddr),
        .q_done(q_done), .i_grant(i_grant), .d_grant(d_grant),
        .i_done(i_done), .d_done(d_done), .busy(busy)
    );

    // {q_req,q_i_d,q_write,q_mem,q_paddr,i_grant,d_grant,i_done,d_done,busy}
    typedef logic [28:0] obs_t;

    typedef struct {
        int            rep;
        logic          ireq;
        logic [TW-1:0] itag;
        logic          irom, dpush, dpull;
        logic [TW-1:0] dtag;
        logic          drom, qdone;
        obs_t          exp;
        string         name;
    } vec_t;

    vec_t tbl[$];

    localparam obs_t E0 = '0;

    function automatic obs_t ex(input logic qr, iid, wr, mem, input logic [TW-1:0] pa,
                                input logic ig, dg, id, dd, bs);
        return {qr, iid, wr, mem, pa, ig, dg, id, dd, bs};
    endfunction

    function automatic obs_t ei(input logic [TW-1:0] pa, input logic mem, input logic id);
        return ex(1'b1, 1'b1, 1'b0, mem, pa, 1'b1, 1'b0, id, 1'b0, 1'b1);
    endfunction

    function automatic obs_t ed(input logic wr, input logic mem, input logic [TW-1:0] pa,
                                input logic dd);
        return ex(1'b1, 1'b0, wr, mem, pa, 1'b0, 1'b1, 1'b0, dd, 1'b1);
    endfunction

    function automatic obs_t act();
        return {q_req, q_i_d, q_write, q_mem, q_paddr, i_grant, d_grant, i_done, d_done, busy};
    endfunction

    task automatic add(input string name, input int rep, input logic ireq,
                       input logic [TW-1:0] itag, input logic irom, input logic dpush,
                       input logic dpull, input logic [TW-1:0] dtag, input logic drom,
                       input logic qdone, input obs_t exp);
        vec_t v;
        v.name = name; v.rep = rep; v.ireq = ireq; v.itag = itag; v.irom = irom;
        v.dpush = dpush; v.dpull = dpull; v.dtag = dtag; v.drom = drom;
        v.qdone = qdone; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic ireq, input logic [TW-1:0] itag, input logic irom,
                         input logic dpush, input logic dpull, input logic [TW-1:0] dtag,
                         input logic drom, input logic qdone);
        i_req = ireq; i_tag = itag; i_rom = irom;
        d_push_req = dpush; d_pull_req = dpull; d_tag = dtag; d_rom = drom;
        q_done = qdone;
    endtask

    task automatic chk(input string name, input obs_t exp);
        checks++;
        if (act() !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act(), exp);
        end
    endtask

    task automatic chk_cnt(input string name, input logic [3:0] exp);
        checks++;
        if (dut.cnt !== exp) begin
            errors++;
            $display("FAIL %s cnt got=%0d want=%0d", name, dut.cnt, exp);
        end
    endtask

    // Inputs already driven just after a posedge; observe at negedge, then clock.
    task automatic cyc_chk(input string name, input obs_t exp);
        @(negedge clk);
        chk(name, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, '0, 0, 0, 0, '0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state, then single icache fill with 20-cycle transfer
        add("rst_idle", 1, 0, 20'h0,     0, 0, 0, 20'h0, 0, 0, E0);
        add("i_sample", 1, 1, 20'h12345, 1, 0, 0, 20'h0, 0, 0, E0);
        add("i_fill",  19, 0, 20'h12345, 1, 0, 0, 20'h0, 0, 0, ei(20'h12345, 1, 0));
        add("i_done",   1, 0, 20'h12345, 1, 0, 0, 20'h0, 0, 1, ei(20'h12345, 1, 1));
        add("i_after",  1, 0, 20'h0,     0, 0, 0, 20'h0, 0, 0, E0);
        // push chained into pull, no bubble; push forces q_mem=0
        add("d_sample", 1, 0, 20'h0, 0, 1, 1, 20'h000A0, 1, 0, E0);
        add("d_push",   3, 0, 20'h0, 0, 1, 1, 20'h000A0, 1, 0, ed(1, 0, 20'h000A0, 0));
        add("push_dn",  1, 0, 20'h0, 0, 0, 1, 20'h000B0, 1, 1, ed(1, 0, 20'h000A0, 1));
        add("d_pull",   2, 0, 20'h0, 0, 0, 0, 20'h000B0, 0, 0, ed(0, 1, 20'h000B0, 0));
        add("pull_dn",  1, 0, 20'h0, 0, 0, 0, 20'h000B0, 0, 1, ed(0, 1, 20'h000B0, 1));
        add("d_after",  1, 0, 20'h0, 0, 0, 0, 20'h0,     0, 0, E0);
        // simultaneous i/d: dcache first, idle gap, then 1-cycle icache fill
        add("sim_smp",  1, 1, 20'h33333, 0, 0, 1, 20'h000C0, 0, 0, E0);
        add("sim_d",    2, 1, 20'h33333, 0, 0, 0, 20'h000C0, 0, 0, ed(0, 0, 20'h000C0, 0));
        add("sim_ddn",  1, 1, 20'h33333, 0, 0, 0, 20'h000C0, 0, 1, ed(0, 0, 20'h000C0, 1));
        add("sim_gap",  1, 1, 20'h33333, 0, 0, 0, 20'h0,     0, 0, E0);
        add("sim_i1c",  1, 1, 20'h33333, 0, 0, 0, 20'h0,     0, 1, ei(20'h33333, 0, 1));
        add("sim_end",  1, 0, 20'h0,     0, 0, 0, 20'h0,     0, 0, E0);
        // stray q_done in IDLE
        add("stray",    1, 0, 20'h0, 0, 0, 0, 20'h0, 0, 1, E0);
        add("stray2",   1, 0, 20'h0, 0, 0, 0, 20'h0, 0, 0, E0);

        foreach (tbl[k]) begin
            for (int r = 0; r < tbl[k].rep; r++) begin
                drive(tbl[k].ireq, tbl[k].itag, tbl[k].irom, tbl[k].dpush, tbl[k].dpull,
                      tbl[k].dtag, tbl[k].drom, tbl[k].qdone);
                cyc_chk(tbl[k].name, tbl[k].exp);
            end
        end
        chk_cnt("cnt_pre_starve", 4'd0);

        // starvation: 4 dcache grants, then icache despite pending d_pull_req
        for (int k = 0; k < 5; k++) begin
            drive(1, 20'h44444, 0, 0, 1, 20'h000D0 + 20'(k), 0, 0);
            cyc_chk("starve_idle", E0);
            drive(1, 20'h44444, 0, 0, 1, 20'h000D0 + 20'(k), 0, 1);
            if (k < 4) begin
                chk_cnt("starve_cnt", 4'(k + 1));
                cyc_chk("starve_d", ed(0, 0, 20'h000D0 + 20'(k), 1));
            end else begin
                chk_cnt("starve_cnt_clr", 4'd0);
                cyc_chk("starve_i", ei(20'h44444, 0, 1));
            end
        end
        drive(0, '0, 0, 0, 0, '0, 0, 0);
        cyc_chk("starve_end", E0);

        // mid-transfer input changes are ignored
        drive(1, 20'h11111, 1, 0, 0, '0, 0, 0);
        cyc_chk("mid_smp", E0);
        drive(0, 20'h22222, 0, 0, 0, '0, 0, 0);
        for (int r = 0; r < 3; r++) cyc_chk("mid_hold", ei(20'h11111, 1, 0));
        q_done = 1'b1;
        cyc_chk("mid_done", ei(20'h11111, 1, 1));
        drive(0, '0, 0, 0, 1, 20'h000E0, 1, 0);
        cyc_chk("mid_dsmp", E0);
        drive(0, '0, 0, 0, 0, '0, 0, 0);
        cyc_chk("mid_pull", ed(0, 1, 20'h000E0, 0));
        // reset in the middle of D_PULL abandons the transfer
        reset = 1'b1;
        cyc_chk("rst_pull", ed(0, 1, 20'h000E0, 0));
        @(negedge clk);
        chk("rst_out", E0);
        chk_cnt("rst_cnt", 4'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc_chk("rst_after", E0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
